// File: rtl/adder_share_arbiter_if.sv
// Bundle of request/response signals between the requesters, the result consumer and
// adder_share_arbiter.
//   req_valid/req_a/req_b : per-requester operands; slice [64*i +: 64] belongs to requester i
//   req_ready             : one-hot grant back to the requesters
//   rsp_*                 : registered result, tagged with the owning requester index
//   busy                  : an operation is in flight
// master: requester/consumer side. slave: the arbiter.
interface adder_share_arbiter_if #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned ID_W = $clog2(NREQ)
);

  logic [NREQ-1:0]    req_valid;
  logic [64*NREQ-1:0] req_a;
  logic [64*NREQ-1:0] req_b;
  logic [NREQ-1:0]    req_ready;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [ID_W-1:0]    rsp_id;
  logic [63:0]        rsp_sum;
  logic               rsp_cout;
  logic               rsp_ovf;
  logic               busy;

  modport master (
    output req_valid,
    output req_a,
    output req_b,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_id,
    input  rsp_sum,
    input  rsp_cout,
    input  rsp_ovf,
    input  busy
  );

  modport slave (
    input  req_valid,
    input  req_a,
    input  req_b,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_id,
    output rsp_sum,
    output rsp_cout,
    output rsp_ovf,
    output busy
  );

endinterface

// File: rtl/adder_share_arbiter.sv
// Shares a single 64-bit ripple-carry adder (carry-in 0) among NREQ requesters.
// Round-robin grant, one operation in flight, IDLE -> CALC -> RESP -> IDLE.
// Operands are captured on the grant handshake and the result is registered at the end of
// CALC, so the full carry chain gets a whole cycle.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : adder_share_arbiter_if.slave (request operands/grant, response, busy)
module adder_share_arbiter #(
  parameter int unsigned NREQ = 3
) (
  input logic                 clk,
  input logic                 rst_n,
  adder_share_arbiter_if.slave bus
);

  localparam int unsigned ID_W = $clog2(NREQ);

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StResp
  } state_e;

  state_e          state_q, state_d;
  logic [ID_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [63:0]     op_a_q, op_a_d;
  logic [63:0]     op_b_q, op_b_d;
  logic [ID_W-1:0] op_id_q, op_id_d;
  logic [63:0]     sum_q, sum_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;
  logic [ID_W-1:0] id_q, id_d;

  // (base + k) mod NREQ, valid for base < NREQ and k <= NREQ.
  function automatic logic [ID_W-1:0] rot_idx(input logic [ID_W-1:0] base,
                                              input int unsigned k);
    int unsigned s;
    s = 32'(base) + k;
    if (s >= NREQ) begin
      s = s - NREQ;
    end
    return ID_W'(s);
  endfunction

  // Round-robin search starting at rr_ptr_q; the first valid requester wins.
  logic            found;
  logic [ID_W-1:0] grant_idx;
  logic [ID_W-1:0] cand;

  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = rot_idx(rr_ptr_q, k);
      if (!found && bus.req_valid[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Grant is only offered in IDLE, so a request seen here always completes a handshake.
  logic [NREQ-1:0] grant_oh;

  always_comb begin
    grant_oh = '0;
    if (state_q == StIdle && found) begin
      grant_oh[grant_idx] = 1'b1;
    end
  end

  // Operand mux for the granted requester.
  logic [63:0] sel_a;
  logic [63:0] sel_b;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        sel_a = bus.req_a[64*i +: 64];
        sel_b = bus.req_b[64*i +: 64];
      end
    end
  end

  // Shared ripple-carry adder, fed only from the operand registers.
  logic [64:0] carry;
  logic [63:0] add_sum;
  logic        add_cout;
  logic        add_ovf;

  always_comb begin
    carry[0] = 1'b0;
    add_sum  = '0;
    for (int unsigned i = 0; i < 64; i++) begin
      add_sum[i]   = op_a_q[i] ^ op_b_q[i] ^ carry[i];
      carry[i + 1] = (op_a_q[i] & op_b_q[i]) | (carry[i] & (op_a_q[i] ^ op_b_q[i]));
    end
  end

  assign add_cout = carry[64];
  // Signed overflow: like-signed operands yielding a result of the other sign.
  assign add_ovf  = (op_a_q[63] == op_b_q[63]) && (add_sum[63] != op_a_q[63]);

  // Next-state logic.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    op_a_d   = op_a_q;
    op_b_d   = op_b_q;
    op_id_d  = op_id_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    id_d     = id_q;

    unique case (state_q)
      StIdle: begin
        if (found) begin
          op_a_d   = sel_a;
          op_b_d   = sel_b;
          op_id_d  = grant_idx;
          rr_ptr_d = rot_idx(grant_idx, 1);
          state_d  = StCalc;
        end
      end
      StCalc: begin
        sum_d   = add_sum;
        cout_d  = add_cout;
        ovf_d   = add_ovf;
        id_d    = op_id_q;
        state_d = StResp;
      end
      StResp: begin
        if (bus.rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      rr_ptr_q <= '0;
      op_a_q   <= '0;
      op_b_q   <= '0;
      op_id_q  <= '0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      id_q     <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      op_a_q   <= op_a_d;
      op_b_q   <= op_b_d;
      op_id_q  <= op_id_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      id_q     <= id_d;
    end
  end

  assign bus.req_ready = grant_oh;
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.busy      = (state_q != StIdle);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_sum   = sum_q;
  assign bus.rsp_cout  = cout_q;
  assign bus.rsp_ovf   = ovf_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter with NREQ=3. Inputs change and outputs are
// sampled around the falling edge, away from the active rising edge.
module tb_adder_share_arbiter;

  localparam int unsigned NREQ = 3;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  adder_share_arbiter_if #(.NREQ(NREQ)) bus ();

  adder_share_arbiter #(.NREQ(NREQ)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic drive_req(input int unsigned i, input logic [63:0] a, input logic [63:0] b);
    bus.req_a[64*i +: 64] = a;
    bus.req_b[64*i +: 64] = b;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.req_ready !== 3'b000) begin
      failures++;
      $display("FAIL reset_ctrl: rsp_valid=%b busy=%b req_ready=%b expected 0 0 000",
               bus.rsp_valid, bus.busy, bus.req_ready);
    end
    checks++;
    if (bus.rsp_sum !== 64'h0 || bus.rsp_id !== 2'd0 || bus.rsp_cout !== 1'b0 ||
        bus.rsp_ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_rsp: sum=%h id=%0d cout=%b ovf=%b expected all zero",
               bus.rsp_sum, bus.rsp_id, bus.rsp_cout, bus.rsp_ovf);
    end
    rst_n = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: rsp_valid=%b busy=%b expected 0 0", bus.rsp_valid, bus.busy);
    end
  endtask

  task automatic test_basic_add();
    @(negedge clk);
    drive_req(0, 64'h17, 64'h25);
    bus.req_valid = 3'b001;
    #1;
    checks++;
    if (bus.req_ready !== 3'b001) begin
      failures++;
      $display("FAIL basic_grant: req_ready=%b expected 001", bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    checks++;
    if (bus.busy !== 1'b1 || bus.rsp_valid !== 1'b0 || bus.req_ready !== 3'b000) begin
      failures++;
      $display("FAIL basic_calc: busy=%b rsp_valid=%b req_ready=%b expected 1 0 000",
               bus.busy, bus.rsp_valid, bus.req_ready);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0) begin
      failures++;
      $display("FAIL basic_rsp: rsp_valid=%b id=%0d expected 1 0", bus.rsp_valid, bus.rsp_id);
    end
    checks++;
    if (bus.rsp_sum !== 64'h3C || bus.rsp_cout !== 1'b0 || bus.rsp_ovf !== 1'b0) begin
      failures++;
      $display("FAIL basic_sum: sum=%h cout=%b ovf=%b expected 3c 0 0",
               bus.rsp_sum, bus.rsp_cout, bus.rsp_ovf);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_idle: rsp_valid=%b busy=%b expected 0 0", bus.rsp_valid, bus.busy);
    end
  endtask

  // Carry-out and signed-overflow corners, one vector per row.
  task automatic test_carry_overflow();
    int unsigned req_tab[3]  = '{1, 2, 2};
    logic [63:0] a_tab[3]    = '{64'hFFFF_FFFF_FFFF_FFFD, 64'h8000_0000_0000_0000,
                                 64'h2000_0000_0000_0000};
    logic [63:0] b_tab[3]    = '{64'h8, 64'h8000_0000_0000_0000, 64'h2000_0000_0000_0000};
    logic [63:0] sum_tab[3]  = '{64'h5, 64'h0, 64'h4000_0000_0000_0000};
    logic        cout_tab[3] = '{1'b1, 1'b1, 1'b0};
    logic        ovf_tab[3]  = '{1'b0, 1'b1, 1'b0};
    logic [2:0]  exp_g;
    for (int v = 0; v < 3; v++) begin
      @(negedge clk);
      drive_req(req_tab[v], a_tab[v], b_tab[v]);
      exp_g = 3'b001 << req_tab[v];
      bus.req_valid = exp_g;
      #1;
      checks++;
      if (bus.req_ready !== exp_g) begin
        failures++;
        $display("FAIL arith_grant[%0d]: req_ready=%b expected %b", v, bus.req_ready, exp_g);
      end
      @(negedge clk);
      bus.req_valid = '0;
      @(negedge clk);
      #1;
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'(req_tab[v]) ||
          bus.rsp_sum !== sum_tab[v]) begin
        failures++;
        $display("FAIL arith_rsp[%0d]: valid=%b id=%0d sum=%h expected 1 %0d %h", v,
                 bus.rsp_valid, bus.rsp_id, bus.rsp_sum, req_tab[v], sum_tab[v]);
      end
      checks++;
      if (bus.rsp_cout !== cout_tab[v] || bus.rsp_ovf !== ovf_tab[v]) begin
        failures++;
        $display("FAIL arith_flags[%0d]: cout=%b ovf=%b expected %b %b", v,
                 bus.rsp_cout, bus.rsp_ovf, cout_tab[v], ovf_tab[v]);
      end
      @(negedge clk);
    end
  endtask

  // All requesters held valid: grants rotate 0,1,2,0 every third cycle.
  task automatic test_back_to_back();
    logic [63:0] sum_tab[3] = '{64'd107, 64'd207, 64'd307};
    logic [2:0]  exp_g;
    int          slot;
    for (int unsigned i = 0; i < NREQ; i++) begin
      drive_req(i, 64'(100 * (i + 1)), 64'd7);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    bus.req_valid = 3'b111;
    for (int c = 0; c < 12; c++) begin
      #1;
      slot  = (c / 3) % 3;
      exp_g = (c % 3 == 0) ? (3'b001 << slot) : 3'b000;
      checks++;
      if (bus.req_ready !== exp_g) begin
        failures++;
        $display("FAIL b2b_grant[%0d]: req_ready=%b expected %b", c, bus.req_ready, exp_g);
      end
      if (c % 3 == 2) begin
        checks++;
        if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'(slot) ||
            bus.rsp_sum !== sum_tab[slot]) begin
          failures++;
          $display("FAIL b2b_rsp[%0d]: valid=%b id=%0d sum=%0d expected 1 %0d %0d", c,
                   bus.rsp_valid, bus.rsp_id, bus.rsp_sum, slot, sum_tab[slot]);
        end
      end
      @(negedge clk);
    end
    bus.req_valid = '0;
  endtask

  // Consumer stalls for 5 cycles; result must hold and no grant may be offered.
  task automatic test_resp_hold();
    bus.rsp_ready = 1'b0;
    bus.req_valid = 3'b111;
    #1;
    checks++;
    if (bus.req_ready !== 3'b010) begin
      failures++;
      $display("FAIL hold_grant: req_ready=%b expected 010", bus.req_ready);
    end
    repeat (2) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd1 || bus.rsp_sum !== 64'd207 ||
          bus.rsp_cout !== 1'b0 || bus.rsp_ovf !== 1'b0 || bus.req_ready !== 3'b000) begin
        failures++;
        $display("FAIL hold_stall[%0d]: valid=%b id=%0d sum=%0d cout=%b ovf=%b rdy=%b expected 1 1 207 0 0 000",
                 k, bus.rsp_valid, bus.rsp_id, bus.rsp_sum, bus.rsp_cout, bus.rsp_ovf,
                 bus.req_ready);
      end
      if (k < 4) @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 3'b100) begin
      failures++;
      $display("FAIL hold_next: rsp_valid=%b req_ready=%b expected 0 100",
               bus.rsp_valid, bus.req_ready);
    end
    bus.req_valid = '0;
  endtask

  task automatic test_reset_in_calc();
    @(negedge clk);
    drive_req(1, 64'd1, 64'd2);
    bus.req_valid = 3'b010;
    #1;
    checks++;
    if (bus.req_ready !== 3'b010) begin
      failures++;
      $display("FAIL rstcalc_grant: req_ready=%b expected 010", bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = '0;
    #1;
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL rstcalc_busy: busy=%b expected 1", bus.busy);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.busy !== 1'b0) begin
      failures++;
      $display("FAIL rstcalc_async: rsp_valid=%b busy=%b expected 0 0", bus.rsp_valid, bus.busy);
    end
    @(negedge clk);
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b0 || bus.rsp_sum !== 64'h0) begin
      failures++;
      $display("FAIL rstcalc_held: rsp_valid=%b sum=%h expected 0 0", bus.rsp_valid, bus.rsp_sum);
    end
    rst_n = 1'b1;
    @(negedge clk);
    bus.req_valid = 3'b111;
    #1;
    checks++;
    if (bus.req_ready !== 3'b001) begin
      failures++;
      $display("FAIL rstcalc_rr: req_ready=%b expected 001", bus.req_ready);
    end
    @(negedge clk);
    bus.req_valid = '0;
    @(negedge clk);
    #1;
    checks++;
    if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 2'd0 || bus.rsp_sum !== 64'd107) begin
      failures++;
      $display("FAIL rstcalc_rsp: valid=%b id=%0d sum=%0d expected 1 0 107",
               bus.rsp_valid, bus.rsp_id, bus.rsp_sum);
    end
    @(negedge clk);
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b1;
    rst_n         = 1'b0;
    test_reset();
    test_basic_add();
    test_carry_overflow();
    test_back_to_back();
    test_resp_hold();
    test_reset_in_calc();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
